// File: rtl/vga_pkg.sv
// Shared types and default 800x600@72 (50 MHz pixel clock) timing for the
// VGA timing generator and its per-axis counters.
package vga_pkg;

  typedef logic [10:0] coord_t;

  // Largest total line/frame length the 11-bit coordinate can represent.
  localparam int unsigned COORD_LIMIT = 2048;

  localparam int unsigned H_DISP_DEF = 800;
  localparam int unsigned H_FP_DEF   = 56;
  localparam int unsigned H_SYNC_DEF = 120;
  localparam int unsigned H_BP_DEF   = 64;
  localparam int unsigned V_DISP_DEF = 600;
  localparam int unsigned V_FP_DEF   = 37;
  localparam int unsigned V_SYNC_DEF = 6;
  localparam int unsigned V_BP_DEF   = 23;
  localparam bit          SYNC_POL_DEF = 1'b1;

  typedef enum logic [1:0] {
    DISPLAY,
    FRONT,
    SYNC,
    BACK
  } axis_phase_t;

  function automatic int unsigned axis_total(input int unsigned disp,
                                             input int unsigned fp,
                                             input int unsigned sync_len,
                                             input int unsigned bp);
    return disp + fp + sync_len + bp;
  endfunction

endpackage

// File: rtl/vga_axis.sv
// One scan axis (horizontal or vertical): a wrapping position counter that
// classifies its next value into display/front/sync/back phases and
// registers the sync level so it lines up with the registered count.
// o_next / o_active describe the value loaded on the coming edge, letting
// the top register its own flags with zero latency relative to the count.
module vga_axis
  import vga_pkg::*;
#(
  parameter int unsigned DISP_LEN = H_DISP_DEF,
  parameter int unsigned FP_LEN   = H_FP_DEF,
  parameter int unsigned SYNC_LEN = H_SYNC_DEF,
  parameter int unsigned BP_LEN   = H_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_advance,
  output coord_t o_count,
  output coord_t o_next,
  output logic   o_sync,
  output logic   o_active,
  output logic   o_wrap
);

  localparam int unsigned TOTAL = axis_total(DISP_LEN, FP_LEN, SYNC_LEN, BP_LEN);

  localparam coord_t C_LAST       = coord_t'(TOTAL - 1);
  localparam coord_t C_FP_START   = coord_t'(DISP_LEN);
  localparam coord_t C_SYNC_START = coord_t'(DISP_LEN + FP_LEN);
  localparam coord_t C_BP_START   = coord_t'(DISP_LEN + FP_LEN + SYNC_LEN);

  coord_t      r_count;
  logic        r_sync;
  coord_t      w_next;
  axis_phase_t w_phase;
  logic        w_terminal;

  assign w_terminal = (r_count == C_LAST);

  // Next count: hold unless advancing, wrap from the terminal count to zero.
  always_comb begin
    w_next = r_count;
    if (i_advance) begin
      w_next = w_terminal ? '0 : r_count + coord_t'(1);
    end
  end

  // Phase of the value about to be loaded.
  always_comb begin
    if (w_next < C_FP_START) begin
      w_phase = DISPLAY;
    end else if (w_next < C_SYNC_START) begin
      w_phase = FRONT;
    end else if (w_next < C_BP_START) begin
      w_phase = SYNC;
    end else begin
      w_phase = BACK;
    end
  end

  // Position and sync registers; reset parks the axis on its last back-porch slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= C_LAST;
      r_sync  <= ~SYNC_POL;
    end else begin
      r_count <= w_next;
      r_sync  <= (w_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_count  = r_count;
  assign o_next   = w_next;
  assign o_sync   = r_sync;
  assign o_active = (w_phase == DISPLAY);
  assign o_wrap   = i_advance & w_terminal;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: spot coordinates, HSYNC/VSYNC, blanking and
// one-cycle SOF/EOF frame delimiters, all registered and aligned to the
// spotX/spotY pair of the same cycle.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output,
// which steps on the cycle after EOF.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HDISP    = H_DISP_DEF,
  parameter int unsigned HFP      = H_FP_DEF,
  parameter int unsigned HSYNC    = H_SYNC_DEF,
  parameter int unsigned HBP      = H_BP_DEF,
  parameter int unsigned VDISP    = V_DISP_DEF,
  parameter int unsigned VFP      = V_FP_DEF,
  parameter int unsigned VSYNC    = V_SYNC_DEF,
  parameter int unsigned VBP      = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] spotX,
  output logic [10:0] spotY,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        SOF,
  output logic        EOF
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned HTOTAL = axis_total(HDISP, HFP, HSYNC, HBP);
  localparam int unsigned VTOTAL = axis_total(VDISP, VFP, VSYNC, VBP);

  localparam coord_t C_X_LAST_VIS = coord_t'(HDISP - 1);
  localparam coord_t C_Y_LAST_VIS = coord_t'(VDISP - 1);

  generate
    if (HTOTAL > COORD_LIMIT) begin : g_htotal_chk
      $error("vga_timing: HTOTAL exceeds 11-bit coordinate range");
    end
    if (VTOTAL > COORD_LIMIT) begin : g_vtotal_chk
      $error("vga_timing: VTOTAL exceeds 11-bit coordinate range");
    end
  endgenerate

  coord_t w_h_count, w_h_next, w_v_count, w_v_next;
  logic   w_h_sync, w_h_active, w_h_wrap;
  logic   w_v_sync, w_v_active, w_v_wrap;

  logic   r_blank;
  logic   r_sof;
  logic   r_eof;

  vga_axis #(
    .DISP_LEN (HDISP),
    .FP_LEN   (HFP),
    .SYNC_LEN (HSYNC),
    .BP_LEN   (HBP),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_advance (1'b1),
    .o_count   (w_h_count),
    .o_next    (w_h_next),
    .o_sync    (w_h_sync),
    .o_active  (w_h_active),
    .o_wrap    (w_h_wrap)
  );

  vga_axis #(
    .DISP_LEN (VDISP),
    .FP_LEN   (VFP),
    .SYNC_LEN (VSYNC),
    .BP_LEN   (VBP),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_advance (w_h_wrap),
    .o_count   (w_v_count),
    .o_next    (w_v_next),
    .o_sync    (w_v_sync),
    .o_active  (w_v_active),
    .o_wrap    (w_v_wrap)
  );

  // Frame flags from the next position; a vertical wrap means the next spot is (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blank <= 1'b1;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      r_blank <= ~(w_h_active & w_v_active);
      r_sof   <= w_v_wrap;
      r_eof   <= (w_h_next == C_X_LAST_VIS) && (w_v_next == C_Y_LAST_VIS);
    end
  end

  assign spotX = w_h_count;
  assign spotY = w_v_count;
  assign hsync = w_h_sync;
  assign vsync = w_v_sync;
  assign blank = r_blank;
  assign SOF   = r_sof;
  assign EOF   = r_eof;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter, stepped one cycle after the EOF pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (r_eof) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a default 800x600 instance for reset and
// line-level timing, and a small-raster, active-low-sync instance for
// frame-level behaviour and mid-frame reset.
module tb_vga_timing;

  // Small raster: HTOTAL = 16+4+6+5 = 31, VTOTAL = 10+3+2+4 = 19, frame = 589 clk.
  localparam int SHT    = 31;
  localparam int SVT    = 19;
  localparam int SFRAME = 589;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        b_reset, s_reset;
  logic [10:0] b_spotX, b_spotY, s_spotX, s_spotY;
  logic        b_hsync, b_vsync, b_blank, b_SOF, b_EOF;
  logic        s_hsync, s_vsync, s_blank, s_SOF, s_EOF;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] b_frame_cnt, s_frame_cnt;
`endif

  vga_timing u_big (
    .clk   (clk),
    .reset (b_reset),
    .spotX (b_spotX),
    .spotY (b_spotY),
    .hsync (b_hsync),
    .vsync (b_vsync),
    .blank (b_blank),
    .SOF   (b_SOF),
    .EOF   (b_EOF)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt (b_frame_cnt)
`endif
  );

  vga_timing #(
    .HDISP    (16),
    .HFP      (4),
    .HSYNC    (6),
    .HBP      (5),
    .VDISP    (10),
    .VFP      (3),
    .VSYNC    (2),
    .VBP      (4),
    .SYNC_POL (1'b0)
  ) u_small (
    .clk   (clk),
    .reset (s_reset),
    .spotX (s_spotX),
    .spotY (s_spotY),
    .hsync (s_hsync),
    .vsync (s_vsync),
    .blank (s_blank),
    .SOF   (s_SOF),
    .EOF   (s_EOF)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt (s_frame_cnt)
`endif
  );

  // Packed view: {spotX, spotY, blank, hsync, vsync, SOF, EOF}
  logic [26:0] b_obs, s_obs;
  assign b_obs = {b_spotX, b_spotY, b_blank, b_hsync, b_vsync, b_SOF, b_EOF};
  assign s_obs = {s_spotX, s_spotY, s_blank, s_hsync, s_vsync, s_SOF, s_EOF};

  task automatic test_reset();
    logic [26:0] exp;
    b_reset = 1'b1;
    s_reset = 1'b1;
    repeat (5) @(negedge clk);
    exp = {11'd1039, 11'd665, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (b_obs !== exp) begin
      errors++;
      $display("FAIL reset_big: got %h want %h", b_obs, exp);
    end
    exp = {11'd30, 11'd18, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (s_obs !== exp) begin
      errors++;
      $display("FAIL reset_small: got %h want %h", s_obs, exp);
    end
    b_reset = 1'b0;
    s_reset = 1'b0;
    @(negedge clk);
    exp = {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (b_obs !== exp) begin
      errors++;
      $display("FAIL first_edge_big: got %h want %h", b_obs, exp);
    end
    exp = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (s_obs !== exp) begin
      errors++;
      $display("FAIL first_edge_small: got %h want %h", s_obs, exp);
    end
  endtask

  // One full 800x600 line starting from (0,0).
  task automatic test_line();
    logic [26:0] exp;
    int x, y, hs_cnt, hs_first, bl_first;
    hs_cnt   = 0;
    hs_first = -1;
    bl_first = -1;
    for (int i = 1; i <= 1040; i++) begin
      @(negedge clk);
      x = i % 1040;
      y = i / 1040;
      exp = {11'(x), 11'(y), (x >= 800), (x >= 856 && x < 976), 1'b0,
             (x == 0 && y == 0), 1'b0};
      checks++;
      if (b_obs !== exp) begin
        errors++;
        $display("FAIL line_step%0d: got %h want %h", i, b_obs, exp);
      end
      if (b_hsync === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(b_spotX);
      end
      if (b_blank === 1'b1 && bl_first < 0) bl_first = int'(b_spotX);
    end
    checks++;
    if (hs_cnt !== 120) begin
      errors++;
      $display("FAIL hsync_width: got %0d want 120", hs_cnt);
    end
    checks++;
    if (hs_first !== 856) begin
      errors++;
      $display("FAIL hsync_start: got %0d want 856", hs_first);
    end
    checks++;
    if (bl_first !== 800) begin
      errors++;
      $display("FAIL blank_start: got %0d want 800", bl_first);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++;
    if (b_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL big_frame_cnt: got %0d want 0", b_frame_cnt);
    end
`endif
  endtask

  // Three small frames from a fresh reset, checked cycle by cycle.
  task automatic test_frames();
    logic [26:0] exp;
    logic e_eof, prev_eof;
    int x, y, sof_cnt, eof_cnt, both_cnt, disp_cnt, vs_cnt, vs_first;
    int last_sof, last_eof, period, gap;
    int exp_fc;
    s_reset = 1'b1;
    repeat (2) @(negedge clk);
    s_reset = 1'b0;
    @(negedge clk);
    exp = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (s_obs !== exp) begin
      errors++;
      $display("FAIL frame_start: got %h want %h", s_obs, exp);
    end
    sof_cnt = 0; eof_cnt = 0; both_cnt = 0; disp_cnt = 0; vs_cnt = 0;
    vs_first = -1; last_sof = 0; last_eof = -1; period = -1; gap = -1;
    exp_fc = 0; prev_eof = 1'b0;
    for (int c = 1; c <= 3 * SFRAME; c++) begin
      @(negedge clk);
      x = c % SHT;
      y = (c / SHT) % SVT;
      e_eof = (x == 15 && y == 9);
      exp = {11'(x), 11'(y), (x >= 16 || y >= 10), !(x >= 20 && x < 26),
             !(y >= 13 && y < 15), (x == 0 && y == 0), e_eof};
      checks++;
      if (s_obs !== exp) begin
        errors++;
        $display("FAIL frame_c%0d: got %h want %h", c, s_obs, exp);
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (prev_eof) exp_fc++;
      checks++;
      if (s_frame_cnt !== 16'(exp_fc)) begin
        errors++;
        $display("FAIL frame_cnt_c%0d: got %0d want %0d", c, s_frame_cnt, exp_fc);
      end
`endif
      prev_eof = e_eof;
      if (s_SOF === 1'b1) begin
        sof_cnt++;
        period   = c - last_sof;
        last_sof = c;
        if (last_eof >= 0) gap = c - last_eof;
      end
      if (s_EOF === 1'b1) begin
        eof_cnt++;
        last_eof = c;
      end
      if (s_SOF === 1'b1 && s_EOF === 1'b1) both_cnt++;
      if (s_blank === 1'b0) disp_cnt++;
      if (s_vsync === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = c;
      end
    end
    checks++;
    if (sof_cnt !== 3) begin
      errors++;
      $display("FAIL sof_count: got %0d want 3", sof_cnt);
    end
    checks++;
    if (eof_cnt !== 3) begin
      errors++;
      $display("FAIL eof_count: got %0d want 3", eof_cnt);
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL sof_eof_overlap: got %0d want 0", both_cnt);
    end
    checks++;
    if (period !== SFRAME) begin
      errors++;
      $display("FAIL sof_period: got %0d want %0d", period, SFRAME);
    end
    // EOF sits at index 9*31+15 = 294 in the frame, so SOF follows 589-294 clk later.
    checks++;
    if (gap !== 295) begin
      errors++;
      $display("FAIL eof_to_sof: got %0d want 295", gap);
    end
    checks++;
    if (disp_cnt !== 3 * 160) begin
      errors++;
      $display("FAIL visible_cycles: got %0d want 480", disp_cnt);
    end
    checks++;
    if (vs_cnt !== 3 * 2 * SHT) begin
      errors++;
      $display("FAIL vsync_cycles: got %0d want 186", vs_cnt);
    end
    checks++;
    if (vs_first !== 13 * SHT) begin
      errors++;
      $display("FAIL vsync_start: got %0d want 403", vs_first);
    end
  endtask

  // Reset pulsed for one clk at (8,5) of the small raster.
  task automatic test_mid_reset();
    logic [26:0] exp;
    repeat (5 * SHT + 8) @(negedge clk);
    checks++;
    if ({s_spotX, s_spotY} !== {11'd8, 11'd5}) begin
      errors++;
      $display("FAIL mid_position: got %h want %h", {s_spotX, s_spotY}, {11'd8, 11'd5});
    end
    s_reset = 1'b1;
    @(negedge clk);
    s_reset = 1'b0;
    exp = {11'd30, 11'd18, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (s_obs !== exp) begin
      errors++;
      $display("FAIL mid_reset_values: got %h want %h", s_obs, exp);
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++;
    if (s_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_frame_cnt: got %0d want 0", s_frame_cnt);
    end
`endif
    @(negedge clk);
    exp = {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (s_obs !== exp) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h want %h", s_obs, exp);
    end
  endtask

  initial begin
    b_reset = 1'b1;
    s_reset = 1'b1;
    test_reset();
    test_line();
    test_frames();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
